// File: rtl/btn_toggle_ctrl.sv
// Push-button front end for the tff: synchronise, debounce, one t pulse per accepted press.
// Optional auto-repeat while held is enabled by defining BTN_TOGGLE_AUTO_REPEAT_EN.
module btn_toggle_ctrl #(
  parameter int DB_CYCLES     = 4,
  parameter int CNT_W         = 8,
  parameter int REPEAT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  output logic             t,
  output logic             held,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  if (DB_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("btn_toggle_ctrl: DB_CYCLES must be >= 1 and REPEAT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

  state_t         state, state_nx;
  logic           s1, btn_s;
  logic [DBW-1:0] db_cnt, db_cnt_nx;
  logic           t_nx, held_nx;

`ifdef BTN_TOGGLE_AUTO_REPEAT_EN
  localparam int RPW = $clog2(REPEAT_CYCLES);
  localparam logic [RPW-1:0] RP_LAST = RPW'(REPEAT_CYCLES - 1);
  logic [RPW-1:0] rp_cnt, rp_cnt_nx;
`endif

  // btn_in is asynchronous; nothing but btn_s may feed the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1    <= btn_in;
      btn_s <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    db_cnt_nx = db_cnt;
    t_nx      = 1'b0;
`ifdef BTN_TOGGLE_AUTO_REPEAT_EN
    rp_cnt_nx = rp_cnt;
`endif
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nx  = DB_PRESS;
          db_cnt_nx = '0;
        end
      end
      DB_PRESS: begin
        if (!btn_s) begin
          state_nx = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_nx = HELD;
          t_nx     = 1'b1;
`ifdef BTN_TOGGLE_AUTO_REPEAT_EN
          rp_cnt_nx = '0;
`endif
        end else begin
          db_cnt_nx = db_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nx  = DB_RELEASE;
          db_cnt_nx = '0;
        end
`ifdef BTN_TOGGLE_AUTO_REPEAT_EN
        else if (rp_cnt == RP_LAST) begin
          t_nx      = 1'b1;
          rp_cnt_nx = '0;
        end else begin
          rp_cnt_nx = rp_cnt + 1'b1;
        end
`endif
      end
      DB_RELEASE: begin
        if (btn_s) begin
          state_nx = HELD;
        end else if (db_cnt == DB_LAST) begin
          state_nx = IDLE;
        end else begin
          db_cnt_nx = db_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // held is registered from the next state so it rises with t.
    held_nx = (state_nx == HELD) || (state_nx == DB_RELEASE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt    <= '0;
      t         <= 1'b0;
      held      <= 1'b0;
      press_cnt <= '0;
    end else begin
      db_cnt <= db_cnt_nx;
      t      <= t_nx;
      held   <= held_nx;
      if (t_nx) press_cnt <= press_cnt + 1'b1;
    end
  end

`ifdef BTN_TOGGLE_AUTO_REPEAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rp_cnt <= '0;
    else      rp_cnt <= rp_cnt_nx;
  end
`endif

endmodule

// File: tb/tb_btn_toggle_ctrl.sv
// Bench for btn_toggle_ctrl: expected t pulses (cycle, count) are queued when a press
// is driven and matched against the DUT as pulses appear.
module tb_btn_toggle_ctrl;

  localparam int DB    = 4;
  localparam int CW    = 2;
  localparam int REP   = 16;
  localparam int CMOD  = 1 << CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn_in;
  logic          t;
  logic          held;
  logic [CW-1:0] press_cnt;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   cyc = 0;
  int   exp_cnt = 0;
  int   n_compared = 0;
  int   n_mismatched = 0;

  btn_toggle_ctrl #(
    .DB_CYCLES(DB),
    .CNT_W(CW),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .t(t),
    .held(held),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_compared++;
    if (observed != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic push_one(input int at_cyc);
    exp_t x;
    exp_cnt = (exp_cnt + 1) % CMOD;
    x.cyc = at_cyc;
    x.cnt = exp_cnt;
    sb_q.push_back(x);
  endtask

  // A clean high level sampled on edges n+1..n+h is seen by the FSM on edges n+3..n+h+2.
  task automatic push_press(input int n, input int h);
    int acc;
    acc = n + DB + 3;
    if (h >= DB + 1) begin
      push_one(acc);
`ifdef BTN_TOGGLE_AUTO_REPEAT_EN
      for (int k = acc + REP; k <= n + h + 2; k += REP) push_one(k);
`endif
    end
  endtask

  task automatic applyStimulus(input logic level, input int cycles);
    btn_in = level;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_t", t, 0);
    checkOutput("rst_held", held, 0);
    checkOutput("rst_cnt", press_cnt, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0;
  endtask

  // Scoreboard consumer: every t pulse must match the oldest expected entry exactly.
  always @(negedge clk) begin
    if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
      e = sb_q.pop_front();
      checkOutput("t_missing", 0, 1);
    end
    if (t === 1'b1) begin
      if (sb_q.size() == 0) begin
        checkOutput("t_unexpected", 1, 0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("t_cycle", cyc, e.cyc);
        checkOutput("t_cnt", int'(press_cnt), e.cnt);
      end
    end
  end

  initial begin
    int n;
    int m;
    int r;
    btn_in = 1'b0;
    rst    = 1'b1;

    // clean press, held 40 cycles
    do_reset();
    n = cyc;
    push_press(n, 40);
    applyStimulus(1'b1, 40);
    m = cyc;
    btn_in = 1'b0;
    repeat (DB + 2) @(negedge clk);
    checkOutput("clean_held_before_fall", held, 1);
    @(negedge clk);
    checkOutput("clean_held_fall", held, 0);
    repeat (10) @(negedge clk);
    checkOutput("clean_cnt", press_cnt, exp_cnt);
    checkOutput("clean_sb_empty", sb_q.size(), 0);
    $display("[TB] clean press done at cycle %0d (release from %0d)", cyc, m);

    // press bounce: never long enough to accept
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 15);
    checkOutput("bounce_cnt", press_cnt, exp_cnt);
    checkOutput("bounce_held", held, 0);
    checkOutput("bounce_sb_empty", sb_q.size(), 0);

    // release bounce: held must ride through the glitch
    n = cyc;
    push_press(n, 10);
    applyStimulus(1'b1, 10);
    for (int i = 0; i < 13; i++) begin
      btn_in = (i == 2);
      @(negedge clk);
      checkOutput("relbounce_held", held, (cyc <= n + 19) ? 1 : 0);
    end
    checkOutput("relbounce_cnt", press_cnt, exp_cnt);
    checkOutput("relbounce_sb_empty", sb_q.size(), 0);

    // counter wrap with a 2-bit count
    do_reset();
    for (int p = 0; p < 5; p++) begin
      n = cyc;
      push_press(n, 8);
      applyStimulus(1'b1, 8);
      applyStimulus(1'b0, 12);
      checkOutput("wrap_cnt", press_cnt, exp_cnt);
    end
    checkOutput("wrap_sb_empty", sb_q.size(), 0);

    // reset asserted during the t cycle while the button stays pressed
    do_reset();
    n = cyc;
    push_one(n + DB + 3);
    btn_in = 1'b1;
    repeat (DB + 3) @(negedge clk);
    checkOutput("midrst_t_before", t, 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("midrst_t", t, 0);
    checkOutput("midrst_held", held, 0);
    checkOutput("midrst_cnt", press_cnt, 0);
    checkOutput("midrst_sb_empty", sb_q.size(), 0);
    exp_cnt = 0;
    repeat (3) @(negedge clk);
    r = cyc;
    rst = 1'b1;
    push_press(r, 20);
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 15);
    checkOutput("midrst_cnt_after", press_cnt, exp_cnt);
    checkOutput("midrst_sb_empty_after", sb_q.size(), 0);

    // long hold: one pulse, or a pulse every REP cycles with auto-repeat
    do_reset();
    n = cyc;
    push_press(n, DB + 3 + 60);
    applyStimulus(1'b1, DB + 3 + 60);
    applyStimulus(1'b0, 15);
    checkOutput("hold_cnt", press_cnt, exp_cnt);
    checkOutput("hold_sb_empty", sb_q.size(), 0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/btn_toggle_ctrl.md
# btn_toggle_ctrl

Upstream control stage for the `tff` toggle flip-flop: takes a raw, asynchronous push-button level, synchronises and debounces it, and emits exactly one single-cycle `t` pulse per accepted press. Its `t` output drives the `tff` `t` input directly on the same `clk`. It also keeps a wrapping count of accepted presses for observation.

## Interface
- `DB_CYCLES`, default 4: consecutive stable synchronised samples required to accept a press or a release. Legal range is at least 1.
- `CNT_W`, default 8: width of `press_cnt`.
- `REPEAT_CYCLES`, default 16: auto-repeat period in cycles. Used only when `BTN_TOGGLE_AUTO_REPEAT_EN` is defined. Legal range is at least 2.

- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset. Asserting it (low) resets the block immediately. Release is sampled on `clk`.
- `btn_in`  input  1  raw button level, asynchronous to `clk`, may bounce.
- `t`  output  1  toggle pulse, registered, high for exactly one cycle per accepted event.
- `held`  output  1  registered; high while the FSM is in HELD or DB_RELEASE.
- `press_cnt`  output  CNT_W  number of accepted `t` pulses, modulo 2^CNT_W.

## Operation
- **Synchroniser.** Two flops, `btn_in` → `s1` → `btn_s`. All FSM decisions use `btn_s` only.
- **Debounce counter.** `db_cnt`, width clog2(DB_CYCLES) with a minimum of 1 bit.
- **States:** IDLE, DB_PRESS, HELD, DB_RELEASE.
- **IDLE**
  - `btn_s`=1 → DB_PRESS, `db_cnt`←0.
- **DB_PRESS**
  - `btn_s`=0 → IDLE (bounce rejected, no pulse).
  - `btn_s`=1 and `db_cnt`==DB_CYCLES-1 → HELD; `t`←1; `press_cnt`←`press_cnt`+1.
  - Otherwise `db_cnt`←`db_cnt`+1.
- **HELD**
  - `btn_s`=0 → DB_RELEASE, `db_cnt`←0.
- **DB_RELEASE**
  - `btn_s`=1 → HELD. No pulse and no count.
  - `btn_s`=0 and `db_cnt`==DB_CYCLES-1 → IDLE.
  - Otherwise `db_cnt`←`db_cnt`+1.
- **`t` deassertion.** `t` defaults to 0 on every edge unless set by the rules above. Back-to-back pulses are possible only through auto-repeat.
- **`press_cnt` arithmetic.** Unsigned. Wraps from 2^CNT_W-1 to 0 with no flag.
- **Reset value of every output:** `t`=0, `held`=0, `press_cnt`=0. Reset also sets the FSM to IDLE, `db_cnt`=0, `s1`=`btn_s`=0, and the repeat counter to 0.
- **Reset mid-operation.** Asserting reset in any state, including during a `t` pulse, clears `t` the same instant. It produces no extra pulse after release. If the button is still pressed at release, the press is re-debounced from IDLE.

## Timing
- **Press latency.** Number edges from 1, where edge 1 is the first rising edge that samples `btn_in`=1, and assume the level stays stable. Then:
  - `btn_s`=1 after edge 2.
  - DB_PRESS is entered at edge 3.
  - `t` goes high after edge DB_CYCLES+3 (edge 7 for the default) and stays high for one cycle.
- **`press_cnt`** updates on the same edge that `t` rises.
- **`held`** rises on the same edge as `t`. It falls on the edge that DB_RELEASE → IDLE: DB_CYCLES+3 edges after `btn_in` is first sampled low.
- **Minimum accepted pulse.** A `btn_in` high pulse shorter than DB_CYCLES+1 sampled cycles never produces `t`.
- **Minimum press-to-press spacing.** Release debounce plus press debounce apply, so consecutive `t` pulses from separate presses are at least 2·DB_CYCLES+2 cycles apart.

## Configuration
- **`BTN_TOGGLE_AUTO_REPEAT_EN` defined**
  - A repeat counter `rp_cnt` is cleared on DB_PRESS→HELD.
  - In HELD with `btn_s`=1: if `rp_cnt`==REPEAT_CYCLES-1 then `t`←1, `press_cnt`++, `rp_cnt`←0; otherwise `rp_cnt`++.
  - `rp_cnt` freezes in DB_RELEASE and resumes if the FSM returns to HELD.
  - Pulses therefore appear every REPEAT_CYCLES cycles while the button is held.
- **Macro undefined**
  - No repeat logic is synthesised.
  - Exactly one `t` per press regardless of hold time.

## Test plan
- **Clean press**, DB_CYCLES=4: `btn_in` 0→1 held for 40 cycles, then 0.
  - Required: one `t` pulse after edge 7, `press_cnt`=1.
  - `held` falls 7 edges after the first low sample.
  - No further `t`.
- **Press bounce**: `btn_in` high for 3 cycles, low for 2, high for 3, then low.
  - Required: `t` never asserts, `press_cnt` stays 0, the FSM returns to IDLE.
- **Release bounce**: after an accepted press, `btn_in` goes low for 2 cycles, high for 1, then low for 10.
  - Required: `held` stays 1 through the bounce, then falls.
  - Exactly one `t` total and `press_cnt`=1.
- **Wrap**, CNT_W=2: five clean presses spaced 20 cycles apart.
  - Required: `press_cnt` sequence 1, 2, 3, 0, 1.
  - Five `t` pulses, each exactly 1 cycle wide.
- **Reset mid-operation**: assert `rst` low asynchronously during the `t` cycle of a press, hold for 3 cycles while `btn_in` stays 1, then release.
  - Required: `t`, `held` and `press_cnt` are 0 immediately on assertion.
  - A new `t` appears DB_CYCLES+3 edges after release, and `press_cnt`=1.
- **Auto-repeat**, with the macro defined and REPEAT_CYCLES=16: hold `btn_in` for 60 cycles after acceptance.
  - Required: `t` at acceptance, then at +16, +32 and +48 cycles; `press_cnt`=4.
  - With the macro undefined: a single pulse and `press_cnt`=1.
